// File: rtl/csr_access_ctrl_pkg.sv
// Shared CSR definitions: op encodings, CSR address map and controller FSM states.
// Used by the access controller and by the CSR register file.
package csr_access_ctrl_pkg;

  localparam int unsigned CSR_ADDR_W = 14;
  localparam int unsigned CSR_DATA_W = 32;

  typedef enum logic [1:0] {
    CSR_OP_RD   = 2'd0,
    CSR_OP_WR   = 2'd1,
    CSR_OP_XCHG = 2'd2
  } csr_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } csr_state_e;

  localparam logic [CSR_ADDR_W-1:0] CSR_CRMD          = 14'h0000;
  localparam logic [CSR_ADDR_W-1:0] CSR_PRMD          = 14'h0001;
  localparam logic [CSR_ADDR_W-1:0] CSR_EUEN          = 14'h0002;
  localparam logic [CSR_ADDR_W-1:0] CSR_ECFG          = 14'h0004;
  localparam logic [CSR_ADDR_W-1:0] CSR_ESTAT         = 14'h0005;
  localparam logic [CSR_ADDR_W-1:0] CSR_ERA           = 14'h0006;
  localparam logic [CSR_ADDR_W-1:0] CSR_BADV          = 14'h0007;
  localparam logic [CSR_ADDR_W-1:0] CSR_EENTRY        = 14'h000C;
  localparam logic [CSR_ADDR_W-1:0] CSR_TLBIDX        = 14'h0010;
  localparam logic [CSR_ADDR_W-1:0] CSR_TLBEHI        = 14'h0011;
  localparam logic [CSR_ADDR_W-1:0] CSR_TLBELO0       = 14'h0012;
  localparam logic [CSR_ADDR_W-1:0] CSR_TLBELO1       = 14'h0013;
  localparam logic [CSR_ADDR_W-1:0] CSR_ASID          = 14'h0018;
  localparam logic [CSR_ADDR_W-1:0] CSR_PGDL          = 14'h0019;
  localparam logic [CSR_ADDR_W-1:0] CSR_PGDH          = 14'h001A;
  localparam logic [CSR_ADDR_W-1:0] CSR_PGD           = 14'h001B;
  localparam logic [CSR_ADDR_W-1:0] CSR_CPUID         = 14'h0020;
  localparam logic [CSR_ADDR_W-1:0] CSR_SAVE0         = 14'h0030;
  localparam logic [CSR_ADDR_W-1:0] CSR_SAVE1         = 14'h0031;
  localparam logic [CSR_ADDR_W-1:0] CSR_SAVE2         = 14'h0032;
  localparam logic [CSR_ADDR_W-1:0] CSR_SAVE3         = 14'h0033;
  localparam logic [CSR_ADDR_W-1:0] CSR_TID           = 14'h0040;
  localparam logic [CSR_ADDR_W-1:0] CSR_TCFG          = 14'h0041;
  localparam logic [CSR_ADDR_W-1:0] CSR_TVAL          = 14'h0042;
  localparam logic [CSR_ADDR_W-1:0] CSR_TICLR         = 14'h0044;
  localparam logic [CSR_ADDR_W-1:0] CSR_LLBCTL        = 14'h0060;
  localparam logic [CSR_ADDR_W-1:0] CSR_TLBRENTRY     = 14'h0088;
  localparam logic [CSR_ADDR_W-1:0] CSR_CTAG          = 14'h0098;
  localparam logic [CSR_ADDR_W-1:0] CSR_DMW0          = 14'h0180;
  localparam logic [CSR_ADDR_W-1:0] CSR_DMW1          = 14'h0181;
  localparam logic [CSR_ADDR_W-1:0] CSR_DISABLE_CACHE = 14'h0300;

  // Op code 3 is undefined and behaves as a plain read.
  function automatic logic csr_op_writes(input logic [1:0] op);
    return (op == CSR_OP_WR) || (op == CSR_OP_XCHG);
  endfunction

endpackage

// File: rtl/csr_access_ctrl_wdata_merge.sv
// Combinational CSR write-data merge: wr replaces, xchg replaces only masked bits.
// Any other op passes the old value through unchanged.
module csr_wdata_merge
  import csr_access_ctrl_pkg::*;
(
  input  logic [1:0]            op_i,
  input  logic [CSR_DATA_W-1:0] old_data_i,
  input  logic [CSR_DATA_W-1:0] wdata_i,
  input  logic [CSR_DATA_W-1:0] mask_i,
  output logic [CSR_DATA_W-1:0] merged_o
);

  always_comb begin
    merged_o = old_data_i;
    unique case (op_i)
      CSR_OP_WR:   merged_o = wdata_i;
      CSR_OP_XCHG: merged_o = (old_data_i & ~mask_i) | (wdata_i & mask_i);
      default:     merged_o = old_data_i;
    endcase
  end

endmodule

// File: rtl/csr_access_ctrl.sv
// Serialising CSR access controller: holds one csrrd/csrwr/csrxchg until it is at the
// ROB head, then does the read-modify-write and returns the old value to writeback.
module csr_access_ctrl
  import csr_access_ctrl_pkg::*;
#(
  parameter int unsigned ROB_IDX_W = 6,
  parameter int unsigned PREG_W    = 7
) (
  input  logic                  Clk,
  input  logic                  Rest,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic [1:0]            ReqOp,
  input  logic [CSR_ADDR_W-1:0] ReqCsrAddr,
  input  logic [CSR_DATA_W-1:0] ReqWData,
  input  logic [CSR_DATA_W-1:0] ReqMask,
  input  logic [ROB_IDX_W-1:0]  ReqRobIdx,
  input  logic [PREG_W-1:0]     ReqPreg,
  input  logic                  RobHeadValid,
  input  logic [ROB_IDX_W-1:0]  RobHeadIdx,
  input  logic                  FlushValid,
  output logic [CSR_ADDR_W-1:0] CsrRAddr,
  input  logic [CSR_DATA_W-1:0] CsrRData,
  output logic                  CsrWAble,
  output logic [CSR_ADDR_W-1:0] CsrWAddr,
  output logic [CSR_DATA_W-1:0] CsrWData,
  output logic                  WbValid,
  output logic [PREG_W-1:0]     WbPreg,
  output logic [CSR_DATA_W-1:0] WbData,
  output logic                  DoneValid,
  output logic [ROB_IDX_W-1:0]  DoneRobIdx,
  output logic                  Refetch
);

  csr_state_e            state_q;
  logic [1:0]            op_q;
  logic [CSR_ADDR_W-1:0] addr_q;
  logic [CSR_DATA_W-1:0] wdata_q;
  logic [CSR_DATA_W-1:0] mask_q;
  logic [CSR_DATA_W-1:0] old_q;
  logic [ROB_IDX_W-1:0]  rob_q;
  logic [PREG_W-1:0]     preg_q;

  logic [CSR_ADDR_W-1:0] raddr_q;
  logic                  we_q;
  logic [CSR_ADDR_W-1:0] waddr_q;
  logic [CSR_DATA_W-1:0] csr_wdata_q;
  logic                  wb_valid_q;
  logic [PREG_W-1:0]     wb_preg_q;
  logic [CSR_DATA_W-1:0] wb_data_q;
  logic                  done_valid_q;
  logic [ROB_IDX_W-1:0]  done_rob_q;
  logic                  refetch_q;

  logic [CSR_DATA_W-1:0] merged_d;
  logic                  head_match;

  // The only input-to-output path: flush and reset block the accept immediately.
  assign ReqReady   = (state_q == ST_IDLE) && !FlushValid && Rest;
  assign head_match = RobHeadValid && (RobHeadIdx == rob_q);

  // Merge from the live read data so the merged value is ready at the READ->WRITE edge.
  csr_wdata_merge u_merge (
    .op_i       (op_q),
    .old_data_i (CsrRData),
    .wdata_i    (wdata_q),
    .mask_i     (mask_q),
    .merged_o   (merged_d)
  );

  always_ff @(posedge Clk) begin
    if (!Rest) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
      old_q        <= '0;
      rob_q        <= '0;
      preg_q       <= '0;
      raddr_q      <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      csr_wdata_q  <= '0;
      wb_valid_q   <= 1'b0;
      wb_preg_q    <= '0;
      wb_data_q    <= '0;
      done_valid_q <= 1'b0;
      done_rob_q   <= '0;
      refetch_q    <= 1'b0;
    end else begin
      // Outputs are registered one-state-ahead; each defaults to its idle value.
      raddr_q      <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      csr_wdata_q  <= '0;
      wb_valid_q   <= 1'b0;
      wb_preg_q    <= '0;
      wb_data_q    <= '0;
      done_valid_q <= 1'b0;
      done_rob_q   <= '0;
      refetch_q    <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (ReqValid && ReqReady) begin
            op_q    <= ReqOp;
            addr_q  <= ReqCsrAddr;
            wdata_q <= ReqWData;
            mask_q  <= ReqMask;
            rob_q   <= ReqRobIdx;
            preg_q  <= ReqPreg;
            state_q <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (FlushValid) begin
            state_q <= ST_IDLE;
          end else if (head_match) begin
            raddr_q <= addr_q;
            state_q <= ST_READ;
          end
        end

        ST_READ: begin
          if (FlushValid) begin
            state_q <= ST_IDLE;
          end else begin
            old_q <= CsrRData;
            if (csr_op_writes(op_q)) begin
              we_q        <= 1'b1;
              waddr_q     <= addr_q;
              csr_wdata_q <= merged_d;
              state_q     <= ST_WRITE;
            end else begin
              wb_valid_q   <= 1'b1;
              wb_preg_q    <= preg_q;
              wb_data_q    <= CsrRData;
              done_valid_q <= 1'b1;
              done_rob_q   <= rob_q;
              state_q      <= ST_DONE;
            end
          end
        end

        // Flush is ignored from here on: the op is at the head and committing.
        ST_WRITE: begin
          wb_valid_q   <= 1'b1;
          wb_preg_q    <= preg_q;
          wb_data_q    <= old_q;
          done_valid_q <= 1'b1;
          done_rob_q   <= rob_q;
          refetch_q    <= csr_op_writes(op_q);
          state_q      <= ST_DONE;
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign CsrRAddr   = raddr_q;
  assign CsrWAble   = we_q;
  assign CsrWAddr   = waddr_q;
  assign CsrWData   = csr_wdata_q;
  assign WbValid    = wb_valid_q;
  assign WbPreg     = wb_preg_q;
  assign WbData     = wb_data_q;
  assign DoneValid  = done_valid_q;
  assign DoneRobIdx = done_rob_q;
  assign Refetch    = refetch_q;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Self-checking bench for csr_access_ctrl: directed scenarios plus randomized ops
// checked against a timeline/array model of the CSR access protocol.
module tb_csr_access_ctrl;

  localparam int unsigned ROB_IDX_W = 6;
  localparam int unsigned PREG_W    = 7;

  logic                 Clk = 1'b0;
  logic                 Rest;
  logic                 ReqValid;
  logic                 ReqReady;
  logic [1:0]           ReqOp;
  logic [13:0]          ReqCsrAddr;
  logic [31:0]          ReqWData;
  logic [31:0]          ReqMask;
  logic [ROB_IDX_W-1:0] ReqRobIdx;
  logic [PREG_W-1:0]    ReqPreg;
  logic                 RobHeadValid;
  logic [ROB_IDX_W-1:0] RobHeadIdx;
  logic                 FlushValid;
  logic [13:0]          CsrRAddr;
  logic [31:0]          CsrRData;
  logic                 CsrWAble;
  logic [13:0]          CsrWAddr;
  logic [31:0]          CsrWData;
  logic                 WbValid;
  logic [PREG_W-1:0]    WbPreg;
  logic [31:0]          WbData;
  logic                 DoneValid;
  logic [ROB_IDX_W-1:0] DoneRobIdx;
  logic                 Refetch;

  int checks   = 0;
  int failures = 0;

  // CSR file environment (written by the DUT) and the bench's own expected contents.
  logic [31:0] csr_mem [0:16383] = '{default: 32'h0};
  logic [31:0] ref_mem [0:16383] = '{default: 32'h0};
  logic        pre_we   = 1'b0;
  logic [13:0] pre_addr = '0;
  logic [31:0] pre_data = '0;

  assign CsrRData = csr_mem[CsrRAddr];

  always @(posedge Clk) begin
    if (CsrWAble) csr_mem[CsrWAddr] <= CsrWData;
    else if (pre_we) csr_mem[pre_addr] <= pre_data;
  end

  always #5 Clk = ~Clk;

  csr_access_ctrl #(.ROB_IDX_W(ROB_IDX_W), .PREG_W(PREG_W)) dut (
    .Clk(Clk), .Rest(Rest), .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp(ReqOp),
    .ReqCsrAddr(ReqCsrAddr), .ReqWData(ReqWData), .ReqMask(ReqMask), .ReqRobIdx(ReqRobIdx),
    .ReqPreg(ReqPreg), .RobHeadValid(RobHeadValid), .RobHeadIdx(RobHeadIdx),
    .FlushValid(FlushValid), .CsrRAddr(CsrRAddr), .CsrRData(CsrRData), .CsrWAble(CsrWAble),
    .CsrWAddr(CsrWAddr), .CsrWData(CsrWData), .WbValid(WbValid), .WbPreg(WbPreg),
    .WbData(WbData), .DoneValid(DoneValid), .DoneRobIdx(DoneRobIdx), .Refetch(Refetch)
  );

  // Observations collected by run_op (cycle numbers are relative to the accept cycle = 0).
  int                   obs_acc_ready;
  int                   obs_we_cnt, obs_we_cyc;
  logic [13:0]          obs_waddr;
  logic [31:0]          obs_wdata;
  int                   obs_wb_cnt, obs_wb_cyc;
  logic [31:0]          obs_wb_data;
  logic [PREG_W-1:0]    obs_wb_preg;
  int                   obs_done_cnt, obs_done_cyc;
  logic [ROB_IDX_W-1:0] obs_done_rob;
  int                   obs_ref_cnt, obs_ref_cyc;
  int                   obs_rdy_cyc;
  int                   obs_raddr_err, obs_idle_w_err;

  task automatic poke(input logic [13:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    ref_mem[a] = d;
    @(negedge Clk);
    pre_we = 1'b0;
  endtask

  // Issues one op, delays the ROB head by 'delay' cycles, optionally flushes in
  // cycle 'flush_cyc' (0 = never) and records what the DUT did over a fixed window.
  task automatic run_op(input logic [1:0] op, input logic [13:0] addr, input logic [31:0] wd,
                        input logic [31:0] mk, input logic [ROB_IDX_W-1:0] rob,
                        input logic [PREG_W-1:0] preg, input int delay, input int flush_cyc);
    obs_we_cnt = 0; obs_we_cyc = -1; obs_waddr = '0; obs_wdata = '0;
    obs_wb_cnt = 0; obs_wb_cyc = -1; obs_wb_data = '0; obs_wb_preg = '0;
    obs_done_cnt = 0; obs_done_cyc = -1; obs_done_rob = '0;
    obs_ref_cnt = 0; obs_ref_cyc = -1; obs_rdy_cyc = -1;
    obs_raddr_err = 0; obs_idle_w_err = 0;
    ReqValid = 1'b1; ReqOp = op; ReqCsrAddr = addr; ReqWData = wd; ReqMask = mk;
    ReqRobIdx = rob; ReqPreg = preg; FlushValid = 1'b0; RobHeadValid = 1'b0;
    #1 obs_acc_ready = int'(ReqReady);
    @(negedge Clk);
    ReqValid = 1'b0; ReqOp = 2'($urandom); ReqCsrAddr = 14'($urandom);
    ReqWData = $urandom; ReqMask = $urandom;
    for (int n = 1; n <= delay + 8; n++) begin
      if (n >= 1 + delay) begin
        RobHeadValid = 1'b1; RobHeadIdx = rob;
      end else begin
        RobHeadValid = 1'($urandom);
        RobHeadIdx = ROB_IDX_W'(int'(rob) + 1 + int'($urandom_range(0, 62)));
      end
      FlushValid = (n == flush_cyc);
      #1;
      if (CsrWAble) begin
        if (obs_we_cnt == 0) begin obs_we_cyc = n; obs_waddr = CsrWAddr; obs_wdata = CsrWData; end
        obs_we_cnt++;
      end else if (CsrWAddr != 14'h0 || CsrWData != 32'h0) obs_idle_w_err++;
      if (WbValid) begin
        if (obs_wb_cnt == 0) begin obs_wb_cyc = n; obs_wb_data = WbData; obs_wb_preg = WbPreg; end
        obs_wb_cnt++;
      end
      if (DoneValid) begin
        if (obs_done_cnt == 0) begin obs_done_cyc = n; obs_done_rob = DoneRobIdx; end
        obs_done_cnt++;
      end
      if (Refetch) begin
        if (obs_ref_cnt == 0) obs_ref_cyc = n;
        obs_ref_cnt++;
      end
      if (ReqReady && obs_rdy_cyc < 0) obs_rdy_cyc = n;
      if (CsrRAddr != 14'h0 && CsrRAddr != addr) obs_raddr_err++;
      @(negedge Clk);
    end
    FlushValid = 1'b0; RobHeadValid = 1'b0;
  endtask

  task automatic test_reset();
    Rest = 1'b0; ReqValid = 1'b0; ReqOp = '0; ReqCsrAddr = '0; ReqWData = '0; ReqMask = '0;
    ReqRobIdx = '0; ReqPreg = '0; RobHeadValid = 1'b0; RobHeadIdx = '0; FlushValid = 1'b0;
    repeat (3) @(negedge Clk);
    #1;
    checks++;
    if ({ReqReady, CsrRAddr, CsrWAble, CsrWAddr, CsrWData, WbValid, WbPreg, WbData, DoneValid, DoneRobIdx, Refetch} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b ra=%h we=%b wa=%h wd=%h wb=%b wbd=%h dn=%b rf=%b, required all zero",
               ReqReady, CsrRAddr, CsrWAble, CsrWAddr, CsrWData, WbValid, WbData, DoneValid, Refetch);
    end
    @(negedge Clk);
    Rest = 1'b1;
    #1;
    checks++;
    if (ReqReady !== 1'b1) begin failures++; $display("FAIL reset_release_ready: got %b required 1", ReqReady); end
    @(negedge Clk);
  endtask

  task automatic test_wr();
    poke(14'h0030, 32'h11111111);
    run_op(2'd1, 14'h0030, 32'hDEADBEEF, $urandom, 6'd12, 7'd33, 0, 0);
    checks++;
    if (obs_acc_ready !== 1) begin failures++; $display("FAIL wr_accept: ready=%0d required 1", obs_acc_ready); end
    checks++;
    if (obs_we_cyc !== 3 || obs_we_cnt !== 1) begin
      failures++; $display("FAIL wr_strobe: cycle=%0d count=%0d required cycle=3 count=1", obs_we_cyc, obs_we_cnt);
    end
    checks++;
    if (obs_waddr !== 14'h0030 || obs_wdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL wr_write_value: addr=%h data=%h required 0030/deadbeef", obs_waddr, obs_wdata);
    end
    checks++;
    if (obs_wb_cyc !== 4 || obs_wb_data !== 32'h11111111 || obs_wb_preg !== 7'd33) begin
      failures++; $display("FAIL wr_writeback: cycle=%0d data=%h preg=%0d required 4/11111111/33", obs_wb_cyc, obs_wb_data, obs_wb_preg);
    end
    checks++;
    if (obs_ref_cyc !== 4 || obs_ref_cnt !== 1 || obs_done_cyc !== 4 || obs_done_rob !== 6'd12) begin
      failures++; $display("FAIL wr_done_refetch: refetch cyc=%0d cnt=%0d done cyc=%0d rob=%0d required 4/1/4/12", obs_ref_cyc, obs_ref_cnt, obs_done_cyc, obs_done_rob);
    end
    checks++;
    if (csr_mem[14'h0030] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL wr_csr_file: got %h required deadbeef", csr_mem[14'h0030]);
    end
    ref_mem[14'h0030] = 32'hDEADBEEF;
  endtask

  task automatic test_xchg();
    poke(14'h0000, 32'h000000A8);
    run_op(2'd2, 14'h0000, 32'h00000007, 32'h00000007, 6'd40, 7'd5, 0, 0);
    checks++;
    if (obs_we_cyc !== 3 || obs_wdata !== 32'h000000AF || obs_waddr !== 14'h0000) begin
      failures++; $display("FAIL xchg_write: cycle=%0d addr=%h data=%h required 3/0000/000000af", obs_we_cyc, obs_waddr, obs_wdata);
    end
    checks++;
    if (obs_wb_cyc !== 4 || obs_wb_data !== 32'h000000A8 || obs_ref_cnt !== 1) begin
      failures++; $display("FAIL xchg_writeback: cycle=%0d data=%h refetch=%0d required 4/000000a8/1", obs_wb_cyc, obs_wb_data, obs_ref_cnt);
    end
    ref_mem[14'h0000] = 32'h000000AF;
  endtask

  task automatic test_rd_late();
    poke(14'h0005, 32'h5A5A0F0F);
    run_op(2'd0, 14'h0005, $urandom, $urandom, 6'd3, 7'd100, 5, 0);
    checks++;
    if (obs_we_cnt !== 0) begin failures++; $display("FAIL rd_no_write: strobes=%0d required 0", obs_we_cnt); end
    checks++;
    if (obs_wb_cyc !== 8 || obs_wb_cnt !== 1 || obs_wb_data !== 32'h5A5A0F0F || obs_wb_preg !== 7'd100) begin
      failures++; $display("FAIL rd_late_writeback: cycle=%0d cnt=%0d data=%h preg=%0d required 8/1/5a5a0f0f/100", obs_wb_cyc, obs_wb_cnt, obs_wb_data, obs_wb_preg);
    end
    checks++;
    if (obs_ref_cnt !== 0 || obs_done_cyc !== 8) begin
      failures++; $display("FAIL rd_late_done: refetch=%0d done cyc=%0d required 0/8", obs_ref_cnt, obs_done_cyc);
    end
  endtask

  task automatic test_flush_wait();
    run_op(2'd1, 14'h0031, 32'hCAFEF00D, $urandom, 6'd20, 7'd9, 3, 1);
    checks++;
    if (obs_we_cnt !== 0 || obs_wb_cnt !== 0 || obs_done_cnt !== 0 || obs_ref_cnt !== 0) begin
      failures++; $display("FAIL flush_wait_killed: we=%0d wb=%0d done=%0d refetch=%0d required all 0", obs_we_cnt, obs_wb_cnt, obs_done_cnt, obs_ref_cnt);
    end
    checks++;
    if (obs_rdy_cyc !== 2) begin failures++; $display("FAIL flush_wait_ready: first ready cycle=%0d required 2", obs_rdy_cyc); end
    checks++;
    if (csr_mem[14'h0031] !== ref_mem[14'h0031]) begin
      failures++; $display("FAIL flush_wait_csr: got %h required %h", csr_mem[14'h0031], ref_mem[14'h0031]);
    end
  endtask

  task automatic test_flush_write();
    poke(14'h0032, 32'h01234567);
    run_op(2'd1, 14'h0032, 32'h89ABCDEF, $urandom, 6'd7, 7'd77, 0, 3);
    checks++;
    if (obs_we_cnt !== 1 || obs_wdata !== 32'h89ABCDEF) begin
      failures++; $display("FAIL flush_write_still_writes: cnt=%0d data=%h required 1/89abcdef", obs_we_cnt, obs_wdata);
    end
    checks++;
    if (obs_wb_cyc !== 4 || obs_done_cyc !== 4 || obs_ref_cyc !== 4 || obs_wb_data !== 32'h01234567) begin
      failures++; $display("FAIL flush_write_pulses: wb=%0d done=%0d refetch=%0d data=%h required 4/4/4/01234567", obs_wb_cyc, obs_done_cyc, obs_ref_cyc, obs_wb_data);
    end
    ref_mem[14'h0032] = 32'h89ABCDEF;
  endtask

  task automatic test_back_to_back();
    int acc_cnt, acc1, acc2, wb_n;
    logic [31:0] wb_seen [2];
    logic [31:0] a_val, b_val, m_val, final_val;
    a_val = $urandom; b_val = $urandom; m_val = $urandom;
    poke(14'h0033, 32'h0F0F0F0F);
    final_val = (a_val & ~m_val) | (b_val & m_val);
    acc_cnt = 0; acc1 = -1; acc2 = -1; wb_n = 0;
    wb_seen[0] = '0; wb_seen[1] = '0;
    FlushValid = 1'b0; RobHeadValid = 1'b1;
    for (int n = 0; n < 16; n++) begin
      if (acc_cnt == 0) begin
        ReqValid = 1'b1; ReqOp = 2'd1; ReqCsrAddr = 14'h0033; ReqWData = a_val; ReqMask = $urandom;
        ReqRobIdx = 6'd1; ReqPreg = 7'd11;
      end else if (acc_cnt == 1) begin
        ReqValid = 1'b1; ReqOp = 2'd2; ReqCsrAddr = 14'h0033; ReqWData = b_val; ReqMask = m_val;
        ReqRobIdx = 6'd2; ReqPreg = 7'd22;
      end else begin
        ReqValid = 1'b0;
      end
      RobHeadIdx = (acc_cnt >= 2) ? 6'd2 : 6'd1;
      #1;
      if (WbValid) begin
        if (wb_n < 2) wb_seen[wb_n] = WbData;
        wb_n++;
      end
      if (ReqValid && ReqReady) begin
        if (acc_cnt == 0) acc1 = n; else if (acc_cnt == 1) acc2 = n;
        acc_cnt++;
      end
      @(negedge Clk);
    end
    ReqValid = 1'b0; RobHeadValid = 1'b0;
    checks++;
    if (acc1 !== 0 || acc2 !== 5 || acc_cnt !== 2) begin
      failures++; $display("FAIL b2b_accepts: first=%0d second=%0d count=%0d required 0/5/2", acc1, acc2, acc_cnt);
    end
    checks++;
    if (wb_n !== 2 || wb_seen[0] !== 32'h0F0F0F0F || wb_seen[1] !== a_val) begin
      failures++; $display("FAIL b2b_writeback: count=%0d first=%h second=%h required 2/0f0f0f0f/%h", wb_n, wb_seen[0], wb_seen[1], a_val);
    end
    checks++;
    if (csr_mem[14'h0033] !== final_val) begin
      failures++; $display("FAIL b2b_csr_final: got %h required %h", csr_mem[14'h0033], final_val);
    end
    ref_mem[14'h0033] = final_val;
  endtask

  task automatic test_reset_mid_read();
    int stray;
    poke(14'h0180, 32'hA0A0A0A0);
    ReqValid = 1'b1; ReqOp = 2'd1; ReqCsrAddr = 14'h0180; ReqWData = 32'h12121212; ReqMask = '0;
    ReqRobIdx = 6'd9; ReqPreg = 7'd44; RobHeadValid = 1'b1; RobHeadIdx = 6'd9; FlushValid = 1'b0;
    @(negedge Clk);
    ReqValid = 1'b0;
    @(negedge Clk);
    Rest = 1'b0;
    #1;
    checks++;
    if (CsrRAddr !== 14'h0180 || ReqReady !== 1'b0) begin
      failures++; $display("FAIL rst_read_phase: raddr=%h ready=%b required 0180/0", CsrRAddr, ReqReady);
    end
    @(negedge Clk);
    #1;
    checks++;
    if ({ReqReady, CsrRAddr, CsrWAble, CsrWAddr, CsrWData, WbValid, WbPreg, WbData, DoneValid, DoneRobIdx, Refetch} !== '0) begin
      failures++; $display("FAIL rst_mid_read_outputs: rdy=%b ra=%h we=%b wb=%b dn=%b rf=%b required all zero", ReqReady, CsrRAddr, CsrWAble, WbValid, DoneValid, Refetch);
    end
    @(negedge Clk);
    Rest = 1'b1;
    stray = 0;
    #1;
    checks++;
    if (ReqReady !== 1'b1) begin failures++; $display("FAIL rst_mid_read_idle: ready=%b required 1", ReqReady); end
    for (int n = 0; n < 5; n++) begin
      @(negedge Clk);
      #1;
      if (CsrWAble || WbValid || DoneValid || Refetch) stray++;
    end
    RobHeadValid = 1'b0;
    checks++;
    if (stray !== 0 || csr_mem[14'h0180] !== 32'hA0A0A0A0) begin
      failures++; $display("FAIL rst_mid_read_discard: stray=%0d csr=%h required 0/a0a0a0a0", stray, csr_mem[14'h0180]);
    end
    @(negedge Clk);
  endtask

  task automatic test_random();
    logic [13:0] pool [8];
    logic [1:0]  op;
    logic [13:0] addr;
    logic [31:0] wd, mk, oldv, newv;
    logic [ROB_IDX_W-1:0] rob;
    logic [PREG_W-1:0] preg;
    int delay, flush_cyc, c_read, c_write, c_done, exp_rdy;
    bit wr, killed;
    pool = '{14'h0000, 14'h0001, 14'h0005, 14'h0006, 14'h0018, 14'h0030, 14'h0031, 14'h0181};
    for (int i = 0; i < 8; i++) poke(pool[i], $urandom);
    for (int t = 0; t < 60; t++) begin
      op = 2'($urandom_range(0, 3)); addr = pool[$urandom_range(0, 7)];
      wd = $urandom; mk = $urandom; rob = ROB_IDX_W'($urandom); preg = PREG_W'($urandom);
      delay = $urandom_range(0, 5);
      wr = (op == 2'd1) || (op == 2'd2);
      oldv = ref_mem[addr];
      newv = (op == 2'd1) ? wd : ((oldv & ~mk) | (wd & mk));
      c_read = 2 + delay; c_write = c_read + 1; c_done = c_read + (wr ? 2 : 1);
      flush_cyc = ($urandom_range(0, 2) == 0) ? $urandom_range(1, c_done) : 0;
      killed = (flush_cyc != 0) && (flush_cyc <= c_read);
      exp_rdy = killed ? flush_cyc + 1 : c_done + 1;
      run_op(op, addr, wd, mk, rob, preg, delay, flush_cyc);
      if (!killed && wr) ref_mem[addr] = newv;
      checks++;
      if (obs_acc_ready !== 1 || obs_rdy_cyc !== exp_rdy) begin
        failures++; $display("FAIL rand_handshake[%0d]: accept=%0d ready cyc=%0d required 1/%0d", t, obs_acc_ready, obs_rdy_cyc, exp_rdy);
      end
      checks++;
      if (killed ? (obs_we_cnt !== 0) : (wr ? (obs_we_cnt !== 1 || obs_we_cyc !== c_write || obs_waddr !== addr || obs_wdata !== newv) : (obs_we_cnt !== 0))) begin
        failures++; $display("FAIL rand_write[%0d]: op=%0d killed=%0d cnt=%0d cyc=%0d addr=%h data=%h required write=%0d cyc=%0d addr=%h data=%h", t, op, killed, obs_we_cnt, obs_we_cyc, obs_waddr, obs_wdata, (wr && !killed), c_write, addr, newv);
      end
      checks++;
      if (killed ? (obs_wb_cnt !== 0 || obs_done_cnt !== 0 || obs_ref_cnt !== 0)
                 : (obs_wb_cnt !== 1 || obs_wb_cyc !== c_done || obs_wb_data !== oldv || obs_wb_preg !== preg ||
                    obs_done_cnt !== 1 || obs_done_cyc !== c_done || obs_done_rob !== rob || obs_ref_cnt !== int'(wr) ||
                    (wr && obs_ref_cyc !== c_done))) begin
        failures++; $display("FAIL rand_done[%0d]: op=%0d killed=%0d wb cnt=%0d cyc=%0d data=%h preg=%0d done=%0d rob=%0d refetch=%0d required cyc=%0d data=%h preg=%0d rob=%0d refetch=%0d", t, op, killed, obs_wb_cnt, obs_wb_cyc, obs_wb_data, obs_wb_preg, obs_done_cnt, obs_done_rob, obs_ref_cnt, c_done, oldv, preg, rob, int'(wr));
      end
      checks++;
      if (obs_raddr_err !== 0 || obs_idle_w_err !== 0 || csr_mem[addr] !== ref_mem[addr]) begin
        failures++; $display("FAIL rand_csr_side[%0d]: raddr_err=%0d idle_w_err=%0d csr=%h required 0/0/%h", t, obs_raddr_err, obs_idle_w_err, csr_mem[addr], ref_mem[addr]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wr();
    test_xchg();
    test_rd_late();
    test_flush_wait();
    test_flush_write();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/csr_access_ctrl.md
# csr_access_ctrl

Serialising controller for the CSR register file in the out-of-order LoongArch core. It accepts one csrrd/csrwr/csrxchg micro-op at a time from the issue stage and holds it until that op reaches the ROB head. It then performs the read-modify-write on the CSR file and returns the old value to writeback. Because a CSR write can change CRMD, ASID or DMW state, every write also requests a refetch.

## Interface
- ROB_IDX_W, 6, ROB index width
- PREG_W, 7, physical register tag width
- Clk  in  1  clock; single clock domain
- Rest  in  1  reset; synchronous, active-low
- ReqValid  in  1  issue holds a CSR op
- ReqReady  out  1  controller accepts the op this cycle
- ReqOp  in  2  0 = rd, 1 = wr, 2 = xchg; 3 is treated as rd
- ReqCsrAddr  in  14  CSR number
- ReqWData  in  32  rd-register value, used as the new data
- ReqMask  in  32  rj-register value, used as the xchg mask
- ReqRobIdx  in  ROB_IDX_W  ROB entry of the op
- ReqPreg  in  PREG_W  destination physical register
- RobHeadValid  in  1  ROB head entry is valid
- RobHeadIdx  in  ROB_IDX_W  ROB head index
- FlushValid  in  1  pipeline flush; kills any uncommitted op
- CsrRAddr  out  14  CSR file read address; the file answers combinationally
- CsrRData  in  32  CSR file read data
- CsrWAble  out  1  CSR write strobe
- CsrWAddr  out  14  CSR write address
- CsrWData  out  32  fully merged write value
- WbValid  out  1  one-cycle writeback pulse
- WbPreg  out  PREG_W  writeback tag
- WbData  out  32  old CSR value
- DoneValid  out  1  one-cycle pulse marking the ROB entry complete
- DoneRobIdx  out  ROB_IDX_W  completed ROB entry
- Refetch  out  1  one-cycle pulse, only for wr and xchg

## Operation
- FSM states and transitions:
  - IDLE → WAIT on accept.
  - WAIT → READ when RobHeadValid && RobHeadIdx == held index.
  - READ → WRITE for wr and xchg; READ → DONE for rd.
  - WRITE → DONE.
  - DONE → IDLE.
- Accept condition: ReqReady = (state == IDLE) && !FlushValid && Rest. An accept registers op, address, WData, Mask, RobIdx and Preg.
- READ: CsrRAddr = held address. OldData is captured from CsrRData at the end of the cycle.
- Merge rules:
  - wr: new = WData.
  - xchg: new = (OldData & ~Mask) | (WData & Mask).
  - rd: no write.
- WRITE: CsrWAble = 1, CsrWAddr = held address, CsrWData = merged value. This is the only cycle CsrWAble is high.
- DONE:
  - WbValid = DoneValid = 1, with WbPreg, WbData = OldData and DoneRobIdx.
  - Refetch = 1 only if op is wr or xchg.
- Flush handling:
  - FlushValid in WAIT or READ → IDLE next cycle, with no write and no pulses.
  - FlushValid in WRITE or DONE is ignored; the op is already at the head and committing.
  - FlushValid in IDLE blocks accept.
- Reset while Rest is low:
  - state = IDLE and all held registers = 0.
  - All outputs = 0, including ReqReady.
  - Reset mid-operation discards the op with no write.
- CsrRAddr is 0 outside READ. CsrWAddr and CsrWData are 0 outside WRITE.

## Timing
- Moore outputs, decoded from the state and the held registers. There is no combinational path from any input to an output except ReqReady←FlushValid.
- Latency when the head already matches at the first WAIT cycle:
  - wr/xchg: accept edge → WAIT → READ → WRITE → DONE, so WbValid is high 4 cycles after the accept cycle.
  - rd: WbValid is high 3 cycles after the accept cycle.
- WAIT has no timeout; it waits indefinitely for the head.
- Throughput is one op in flight. The next accept is possible in the cycle after DONE, since IDLE is entered then.
- The CSR write occurs exactly one cycle before the DONE pulses. A following op's READ therefore always sees the updated value.

## Structure
- The shared `define.v` carries:
  - CSR op encodings (CSR_OP_RD, CSR_OP_WR, CSR_OP_XCHG).
  - The 14-bit CSR address constants (CRMD … DISABLE_CACHE), moved out of the CSR file so both blocks use the same set.
  - The FSM state encoding, 3-bit.
- One natural combinational sub-module, `csr_wdata_merge`: inputs op, OldData, WData, Mask; output merged value. It is reusable by any other CSR writer.
- Everything else lives in `csr_access_ctrl`.

## Test plan
- csrwr to SAVE0 (0x30), WData = 0xDEADBEEF, CSR file holds 0x11111111, head already matching:
  - CsrWAble high in the third cycle after accept, with CsrWAddr = 0x30 and CsrWData = 0xDEADBEEF.
  - Next cycle: WbData = 0x11111111 and Refetch = 1.
- csrxchg to CRMD, old = 0x000000A8, WData = 0x00000007, Mask = 0x00000007:
  - CsrWData = 0x000000AF.
  - WbData = 0x000000A8.
- csrrd of ESTAT with head arriving 5 cycles late:
  - The FSM stays in WAIT for 5 cycles.
  - No CsrWAble ever; WbValid only, with Refetch = 0.
- FlushValid asserted in WAIT:
  - The FSM is in IDLE the next cycle, with no CsrWAble and no WbValid.
  - ReqReady = 1 the following cycle.
- FlushValid asserted during WRITE: the write still occurs and the DONE pulses still appear.
- Back-to-back requests:
  - ReqValid held high across two ops; the second accept occurs in the cycle after the first op's DONE.
  - Rest driven low mid-READ: all outputs are 0 next cycle and the state is IDLE.
